// File: rtl/term_char_arbiter_if.sv
// term_char_arbiter_if: valid/ready bundle for the key, host, screen and UART tx character ports.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface term_char_arbiter_if;
  localparam int unsigned CHAR_W = 8;

  logic [CHAR_W-1:0] kbd_data;
  logic              kbd_valid;
  logic              kbd_ready;
  logic [CHAR_W-1:0] host_data;
  logic              host_valid;
  logic              host_ready;
  logic [CHAR_W-1:0] scr_data;
  logic              scr_valid;
  logic              scr_src;
  logic              scr_ready;
  logic [CHAR_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output kbd_data, kbd_valid, host_data, host_valid, scr_ready, tx_ready,
    input  kbd_ready, host_ready, scr_data, scr_valid, scr_src, tx_data, tx_valid
  );

  modport slave (
    input  kbd_data, kbd_valid, host_data, host_valid, scr_ready, tx_ready,
    output kbd_ready, host_ready, scr_data, scr_valid, scr_src, tx_data, tx_valid
  );
endinterface

// File: rtl/term_char_arbiter.sv
// term_char_arbiter: forwards keys to UART tx and shares the screen between host chars and key echo
// with a weighted round-robin. Local echo is compiled in when TERM_LOCAL_ECHO_EN is defined.
module term_char_arbiter #(
  parameter int unsigned HOST_BURST = 4
) (
  input logic                i_clk,
  input logic                i_rst,
  term_char_arbiter_if.slave bus
);
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(HOST_BURST);
`ifdef TERM_LOCAL_ECHO_EN
  localparam logic ECHO_EN = 1'b1;
`else
  localparam logic ECHO_EN = 1'b0;
`endif

  typedef enum logic {GRANT_HOST = 1'b0, GRANT_KBD = 1'b1} grant_e;

  grant_e            last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
  logic [CHAR_W-1:0] kbd_data, kbd_data_nxt;
  logic              tx_pend, tx_pend_nxt;
  logic              echo_pend, echo_pend_nxt;
  logic [CHAR_W-1:0] host_data, host_data_nxt;
  logic              host_pend, host_pend_nxt;
  logic [CHAR_W-1:0] scr_data, scr_data_nxt;
  logic              scr_valid, scr_valid_nxt;
  logic              scr_src, scr_src_nxt;
  logic              kbd_ready, kbd_ready_nxt;
  logic              host_ready, host_ready_nxt;

  logic              kbd_acc, host_acc, slot_free;
  logic              host_req, echo_req;
  logic [CHAR_W-1:0] host_char, echo_char;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= GRANT_KBD;
      burst_cnt  <= '0;
      kbd_data   <= '0;
      tx_pend    <= 1'b0;
      echo_pend  <= 1'b0;
      host_data  <= '0;
      host_pend  <= 1'b0;
      scr_data   <= '0;
      scr_valid  <= 1'b0;
      scr_src    <= 1'b0;
      kbd_ready  <= 1'b1;
      host_ready <= 1'b1;
    end else begin
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      kbd_data   <= kbd_data_nxt;
      tx_pend    <= tx_pend_nxt;
      echo_pend  <= echo_pend_nxt;
      host_data  <= host_data_nxt;
      host_pend  <= host_pend_nxt;
      scr_data   <= scr_data_nxt;
      scr_valid  <= scr_valid_nxt;
      scr_src    <= scr_src_nxt;
      kbd_ready  <= kbd_ready_nxt;
      host_ready <= host_ready_nxt;
    end
  end

  // Accept, tx hand-off and screen arbitration; a char accepted this cycle may win the slot at once
  always_comb begin
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    kbd_data_nxt   = kbd_data;
    tx_pend_nxt    = tx_pend;
    host_data_nxt  = host_data;
    scr_data_nxt   = scr_data;
    scr_valid_nxt  = scr_valid;
    scr_src_nxt    = scr_src;

    kbd_acc   = bus.kbd_valid & kbd_ready;
    host_acc  = bus.host_valid & host_ready;
    slot_free = ~scr_valid | bus.scr_ready;

    if (kbd_acc) begin
      kbd_data_nxt = bus.kbd_data;
      tx_pend_nxt  = 1'b1;
    end else if (tx_pend & bus.tx_ready) begin
      tx_pend_nxt = 1'b0;
    end

    if (host_acc) begin
      host_data_nxt = bus.host_data;
    end

    host_req  = host_pend | host_acc;
    host_char = host_pend ? host_data : bus.host_data;
    echo_req  = ECHO_EN & (echo_pend | kbd_acc);
    echo_char = kbd_acc ? bus.kbd_data : kbd_data;

    host_pend_nxt = host_req;
    echo_pend_nxt = echo_req;

    if (slot_free) begin
      if (host_req && (!echo_req || (burst_cnt < BURST_LIM))) begin
        scr_valid_nxt  = 1'b1;
        scr_data_nxt   = host_char;
        scr_src_nxt    = 1'b0;
        host_pend_nxt  = 1'b0;
        last_grant_nxt = GRANT_HOST;
        burst_cnt_nxt  = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
      end else if (echo_req) begin
        scr_valid_nxt  = 1'b1;
        scr_data_nxt   = echo_char;
        scr_src_nxt    = 1'b1;
        echo_pend_nxt  = 1'b0;
        last_grant_nxt = GRANT_KBD;
        burst_cnt_nxt  = '0;
      end else begin
        scr_valid_nxt = 1'b0;
        burst_cnt_nxt = '0;
      end
    end

    kbd_ready_nxt  = ~tx_pend_nxt & ~echo_pend_nxt;
    host_ready_nxt = ~host_pend_nxt;
  end

  assign bus.kbd_ready  = kbd_ready;
  assign bus.host_ready = host_ready;
  assign bus.scr_data   = scr_data;
  assign bus.scr_valid  = scr_valid;
  assign bus.scr_src    = scr_src;
  assign bus.tx_data    = kbd_data;
  assign bus.tx_valid   = tx_pend;
endmodule

// File: tb/tb_term_char_arbiter.sv
// tb_term_char_arbiter: directed scenarios plus random traffic, checked every cycle against a
// queue-based model of the character routing rules. Honours TERM_LOCAL_ECHO_EN like the design.
module tb_term_char_arbiter;
  localparam int unsigned HOST_BURST = 4;
`ifdef TERM_LOCAL_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  term_char_arbiter_if bus();

  term_char_arbiter #(.HOST_BURST(HOST_BURST)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: chars held inside the arbiter per source, plus the one-deep screen slot
  byte unsigned host_q[$];
  byte unsigned echo_q[$];
  byte unsigned tx_q[$];
  logic [7:0] m_scr_data, m_tx_data;
  bit         m_scr_valid, m_scr_src;
  int         m_run;
  bit         model_ok = 1'b0;
  bit         k_ok, h_ok, free;

  always @(posedge clk) begin
    if (rst) begin
      host_q.delete(); echo_q.delete(); tx_q.delete();
      m_scr_valid = 1'b0; m_scr_src = 1'b0; m_scr_data = 8'h00; m_tx_data = 8'h00;
      m_run = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      k_ok = (tx_q.size() == 0) && (echo_q.size() == 0);
      h_ok = (host_q.size() == 0);
      free = !m_scr_valid || bus.scr_ready;
      if (tx_q.size() != 0 && bus.tx_ready) void'(tx_q.pop_front());
      if (bus.kbd_valid && k_ok) begin
        tx_q.push_back(bus.kbd_data);
        m_tx_data = bus.kbd_data;
        if (ECHO) echo_q.push_back(bus.kbd_data);
      end
      if (bus.host_valid && h_ok) host_q.push_back(bus.host_data);
      if (free) begin
        if (host_q.size() != 0 && (echo_q.size() == 0 || m_run < int'(HOST_BURST))) begin
          m_scr_data = host_q.pop_front(); m_scr_src = 1'b0; m_scr_valid = 1'b1;
          if (m_run < 15) m_run++;
        end else if (echo_q.size() != 0) begin
          m_scr_data = echo_q.pop_front(); m_scr_src = 1'b1; m_scr_valid = 1'b1;
          m_run = 0;
        end else begin
          m_scr_valid = 1'b0; m_run = 0;
        end
      end
    end
  end

  // Compare every cycle, mid-period, once the model has seen a reset
  always @(negedge clk) begin
    if (model_ok) begin
      check("scr_valid",  32'(bus.scr_valid),  32'(m_scr_valid));
      check("scr_data",   32'(bus.scr_data),   32'(m_scr_data));
      check("scr_src",    32'(bus.scr_src),    32'(m_scr_src));
      check("tx_valid",   32'(bus.tx_valid),   32'(tx_q.size() != 0));
      check("tx_data",    32'(bus.tx_data),    32'(m_tx_data));
      check("kbd_ready",  32'(bus.kbd_ready),  32'((tx_q.size() == 0) && (echo_q.size() == 0)));
      check("host_ready", 32'(bus.host_ready), 32'(host_q.size() == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  byte unsigned sent[$];
  byte unsigned got[$];
  bit           srcs[$];
  logic [7:0]   kdat, hdat;
  bit           h_acc, k_acc;
  int           idx, cyc;

  initial begin
    bus.kbd_valid = 1'b0; bus.kbd_data = 8'h00;
    bus.host_valid = 1'b0; bus.host_data = 8'h00;
    bus.scr_ready = 1'b1; bus.tx_ready = 1'b1;

    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_scr_valid",  32'(bus.scr_valid), 32'd0);
    check("rst_tx_valid",   32'(bus.tx_valid), 32'd0);
    check("rst_kbd_ready",  32'(bus.kbd_ready), 32'd1);
    check("rst_host_ready", 32'(bus.host_ready), 32'd1);
    check("rst_scr_data",   32'(bus.scr_data), 32'd0);
    check("rst_scr_src",    32'(bus.scr_src), 32'd0);

    // Single host char reaches the screen for exactly one cycle
    bus.host_valid = 1'b1; bus.host_data = 8'h41;
    tick();
    bus.host_valid = 1'b0;
    check("host_scr_valid", 32'(bus.scr_valid), 32'd1);
    check("host_scr_data",  32'(bus.scr_data), 32'h41);
    check("host_scr_src",   32'(bus.scr_src), 32'd0);
    tick();
    check("host_scr_drop",  32'(bus.scr_valid), 32'd0);

    // Key with tx stalled 5 cycles
    bus.tx_ready = 1'b0;
    bus.kbd_valid = 1'b1; bus.kbd_data = 8'h61;
    tick();
    bus.kbd_valid = 1'b0;
    check("key_tx_valid",  32'(bus.tx_valid), 32'd1);
    check("key_tx_data",   32'(bus.tx_data), 32'h61);
    check("key_scr_valid", 32'(bus.scr_valid), 32'(ECHO));
    check("key_scr_data",  32'(bus.scr_data), ECHO ? 32'h61 : 32'h41);
    check("key_scr_src",   32'(bus.scr_src), 32'(ECHO));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("key_kbd_ready_held", 32'(bus.kbd_ready), 32'd0);
    end
    bus.tx_ready = 1'b1;
    tick();
    check("key_tx_done",     32'(bus.tx_valid), 32'd0);
    check("key_kbd_ready_up", 32'(bus.kbd_ready), 32'd1);
    tick();

    // Both sources continuously valid, both sinks ready
    kdat = 8'h20; hdat = 8'h80;
    bus.kbd_valid = 1'b1; bus.host_valid = 1'b1;
    cyc = 0;
    while (srcs.size() < 20 && cyc < 200) begin
      bus.kbd_data = kdat; bus.host_data = hdat;
      if (bus.scr_valid && bus.scr_ready) srcs.push_back(bus.scr_src);
      k_acc = bus.kbd_valid && bus.kbd_ready;
      h_acc = bus.host_valid && bus.host_ready;
      tick(); cyc++;
      if (k_acc) kdat = kdat + 8'd1;
      if (h_acc) hdat = hdat + 8'd1;
    end
    check("burst_collected", 32'(srcs.size()), 32'd20);
    for (int i = 0; i < srcs.size(); i++)
      check("burst_src_pattern", 32'(srcs[i]), 32'(ECHO && (i % 5 == 4)));
    bus.kbd_valid = 1'b0; bus.host_valid = 1'b0;
    repeat (6) tick();

    // Screen stalled 10 cycles with a char held
    bus.scr_ready = 1'b0;
    bus.host_valid = 1'b1; bus.host_data = 8'h5A;
    tick();
    bus.host_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("stall_valid", 32'(bus.scr_valid), 32'd1);
      check("stall_data",  32'(bus.scr_data), 32'h5A);
      check("stall_src",   32'(bus.scr_src), 32'd0);
      tick();
    end

    // 20 random host chars through a randomly ready screen: none lost or duplicated
    sent.push_back(8'h5A);
    for (int i = 0; i < 20; i++) sent.push_back(8'($urandom));
    idx = 1; cyc = 0;
    while (got.size() < 21 && cyc < 600) begin
      bus.host_valid = (idx < 21);
      bus.host_data  = (idx < 21) ? sent[idx] : 8'h00;
      bus.scr_ready  = 1'($urandom_range(0, 1));
      if (bus.scr_valid && bus.scr_ready) got.push_back(bus.scr_data);
      h_acc = bus.host_valid && bus.host_ready;
      tick(); cyc++;
      if (h_acc) idx++;
    end
    bus.host_valid = 1'b0; bus.scr_ready = 1'b1;
    check("stream_count", 32'(got.size()), 32'd21);
    for (int i = 0; i < got.size(); i++)
      check("stream_char", 32'(got[i]), 32'(sent[i]));
    repeat (3) tick();

    // Reset while everything is pending
    bus.tx_ready = 1'b0; bus.scr_ready = 1'b0;
    bus.host_valid = 1'b1; bus.host_data = 8'hC3;
    bus.kbd_valid = 1'b1; bus.kbd_data = 8'h3C;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_scr_valid",  32'(bus.scr_valid), 32'd0);
    check("mid_rst_tx_valid",   32'(bus.tx_valid), 32'd0);
    check("mid_rst_kbd_ready",  32'(bus.kbd_ready), 32'd1);
    check("mid_rst_host_ready", 32'(bus.host_ready), 32'd1);
    rst = 1'b0;
    bus.host_valid = 1'b0; bus.kbd_valid = 1'b0;
    bus.tx_ready = 1'b1; bus.scr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_scr_quiet", 32'(bus.scr_valid), 32'd0);
      check("post_rst_tx_quiet",  32'(bus.tx_valid), 32'd0);
    end

    // Random traffic with occasional resets, checked by the model
    for (int i = 0; i < 1500; i++) begin
      bus.kbd_valid  = ($urandom_range(0, 2) != 0);
      bus.kbd_data   = 8'($urandom);
      bus.host_valid = ($urandom_range(0, 2) != 0);
      bus.host_data  = 8'($urandom);
      bus.scr_ready  = ($urandom_range(0, 3) != 0);
      bus.tx_ready   = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.kbd_valid = 1'b0; bus.host_valid = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
